// File: rtl/flit_fifo_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------------+
// | flit_fifo_arbiter: packet-aware round-robin arbiter feeding one shared flit FIFO |
// | rev 1.0                                                                          |
// +---------------------------------------------------------------------------------+
module flit_fifo_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 34,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic [N_REQ-1:0]       req_valid_i,
   input  logic [N_REQ*WIDTH-1:0] req_data_i,
   output logic [N_REQ-1:0]       req_ready_o,
   output logic                   fifo_write_o,
   output logic [WIDTH-1:0]       fifo_data_o,
   input  logic                   fifo_full_i,
   input  logic                   fifo_error_i,
   output logic [N_REQ-1:0]       grant_o,
   output logic                   locked_o,
   output logic [CNT_W-1:0]       pkt_cnt_o,
   output logic                   error_o
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_TAIL = 2'b10;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  rr_ptr, rr_nxt;
   logic [IDX_W-1:0]  owner, owner_nxt;
   logic [IDX_W-1:0]  win, cand;
   logic              found;
   logic              pkt_done, proto_err;
   logic [WIDTH-1:0]  flit  [N_REQ];
   logic [1:0]        ftype [N_REQ];
   logic [N_REQ-1:0]  eligible;

   // HEAD (01) and SINGLE (11) share bit 0, which marks a packet start
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign flit[gi]     = req_data_i[gi*WIDTH +: WIDTH];
      assign ftype[gi]    = flit[gi][WIDTH-1 -: 2];
      assign eligible[gi] = req_valid_i[gi] & ftype[gi][0];
   end

   function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] x);
      return (x == IDX_W'(N_REQ - 1)) ? '0 : x + 1'b1;
   endfunction

   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      req_ready_o  = '0;
      fifo_write_o = 1'b0;
      fifo_data_o  = '0;
      state_nxt    = state;
      rr_nxt       = rr_ptr;
      owner_nxt    = owner;
      pkt_done     = 1'b0;
      proto_err    = 1'b0;
      if (arst) begin
         case (state)
            IDLE: begin
               if (found && !fifo_full_i) begin
                  req_ready_o[win] = 1'b1;
                  fifo_write_o     = 1'b1;
                  fifo_data_o      = flit[win];
                  if (ftype[win] == TYPE_HEAD) begin
                     state_nxt = LOCKED;
                     owner_nxt = win;
                  end else begin
                     pkt_done = 1'b1;
                     rr_nxt   = rr_inc(win);
                  end
               end
            end
            LOCKED: begin
               req_ready_o[owner] = ~fifo_full_i;
               if (req_valid_i[owner] && !fifo_full_i) begin
                  fifo_write_o = 1'b1;
                  fifo_data_o  = flit[owner];
                  if (ftype[owner] == TYPE_TAIL) begin
                     state_nxt = IDLE;
                     pkt_done  = 1'b1;
                     rr_nxt    = rr_inc(owner);
                  end else if (ftype[owner][0]) begin
                     // a new packet start inside a packet is forwarded as body
                     proto_err = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         grant_o   <= '0;
         locked_o  <= 1'b0;
         pkt_cnt_o <= '0;
         error_o   <= 1'b0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         owner    <= owner_nxt;
         locked_o <= (state_nxt == LOCKED);
         grant_o  <= (state_nxt == LOCKED) ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner_nxt) : '0;
         if (pkt_done)
            pkt_cnt_o <= pkt_cnt_o + 1'b1;
         if (fifo_error_i || proto_err)
            error_o <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flit_fifo_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------+
// | tb_flit_fifo_arbiter: directed self-checking bench, rev 1.0    |
// +---------------------------------------------------------------+
module tb_flit_fifo_arbiter;

   localparam int N_REQ = 4;
   localparam int WIDTH = 34;
   localparam int CNT_W = 3;
   localparam logic [1:0] BODY   = 2'b00;
   localparam logic [1:0] HEAD   = 2'b01;
   localparam logic [1:0] TAIL   = 2'b10;
   localparam logic [1:0] SINGLE = 2'b11;

   logic                   clk = 1'b0;
   logic                   arst;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       req_ready;
   logic                   fifo_write;
   logic [WIDTH-1:0]       fifo_data;
   logic                   fifo_full;
   logic                   fifo_error;
   logic [N_REQ-1:0]       grant;
   logic                   locked;
   logic [CNT_W-1:0]       pkt_cnt;
   logic                   error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   flit_fifo_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .arst         (arst),
      .req_valid_i  (req_valid),
      .req_data_i   (req_data),
      .req_ready_o  (req_ready),
      .fifo_write_o (fifo_write),
      .fifo_data_o  (fifo_data),
      .fifo_full_i  (fifo_full),
      .fifo_error_i (fifo_error),
      .grant_o      (grant),
      .locked_o     (locked),
      .pkt_cnt_o    (pkt_cnt),
      .error_o      (error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_comb(input string tag, input logic [3:0] rdy, input logic wr, input logic [33:0] d);
      chk({tag, ".ready"}, 64'(req_ready), 64'(rdy));
      chk({tag, ".write"}, 64'(fifo_write), 64'(wr));
      chk({tag, ".data"},  64'(fifo_data),  64'(d));
   endtask

   task automatic chk_reg(input string tag, input logic [3:0] g, input logic l, input logic [2:0] p, input logic e);
      chk({tag, ".grant"},  64'(grant),   64'(g));
      chk({tag, ".locked"}, 64'(locked),  64'(l));
      chk({tag, ".pkt"},    64'(pkt_cnt), 64'(p));
      chk({tag, ".error"},  64'(error),   64'(e));
   endtask

   task automatic put(input int i, input logic [1:0] t, input logic [31:0] p);
      req_valid[i] = 1'b1;
      req_data[i*WIDTH +: WIDTH] = {t, p};
   endtask

   task automatic drop(input int i);
      req_valid[i] = 1'b0;
      req_data[i*WIDTH +: WIDTH] = '0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   initial begin
      arst       = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      fifo_full  = 1'b0;
      fifo_error = 1'b0;
      put(2, SINGLE, 32'h0000_00AA);
      #7;
      chk_comb("reset", 4'b0000, 1'b0, 34'h0);
      chk_reg("reset", 4'b0000, 1'b0, 3'd0, 1'b0);
      #5;
      arst = 1'b1;
      #1;

      // single-flit packet passes through in the same cycle
      chk_comb("single2", 4'b0100, 1'b1, 34'h3_0000_00AA);
      tick;
      chk_reg("single2", 4'b0000, 1'b0, 3'd1, 1'b0);

      // rr pointer now 3: req 3 beats req 0
      drop(2);
      put(0, SINGLE, 32'h1);
      put(3, SINGLE, 32'h3);
      settle;
      chk_comb("rr3", 4'b1000, 1'b1, {SINGLE, 32'h3});
      tick;
      chk_reg("rr3", 4'b0000, 1'b0, 3'd2, 1'b0);

      // req 0 packet while req 1 holds a HEAD
      drop(3);
      put(0, HEAD, 32'h10);
      put(1, HEAD, 32'h20);
      settle;
      chk_comb("p0head", 4'b0001, 1'b1, {HEAD, 32'h10});
      tick;
      chk_reg("p0head", 4'b0001, 1'b1, 3'd2, 1'b0);
      put(0, BODY, 32'h11);
      settle;
      chk_comb("p0body1", 4'b0001, 1'b1, {BODY, 32'h11});
      tick;
      chk_reg("p0body1", 4'b0001, 1'b1, 3'd2, 1'b0);
      put(0, BODY, 32'h12);
      settle;
      chk_comb("p0body2", 4'b0001, 1'b1, {BODY, 32'h12});
      tick;
      chk_reg("p0body2", 4'b0001, 1'b1, 3'd2, 1'b0);
      put(0, TAIL, 32'h13);
      settle;
      chk_comb("p0tail", 4'b0001, 1'b1, {TAIL, 32'h13});
      tick;
      chk_reg("p0tail", 4'b0000, 1'b0, 3'd3, 1'b0);
      drop(0);
      settle;
      chk_comb("p1head", 4'b0010, 1'b1, {HEAD, 32'h20});
      tick;
      chk_reg("p1head", 4'b0010, 1'b1, 3'd3, 1'b0);
      put(1, TAIL, 32'h21);
      settle;
      chk_comb("p1tail", 4'b0010, 1'b1, {TAIL, 32'h21});
      tick;
      chk_reg("p1tail", 4'b0000, 1'b0, 3'd4, 1'b0);

      // FIFO full stalls the owner, then HEAD-in-packet raises a sticky error
      drop(1);
      put(2, HEAD, 32'h30);
      settle;
      chk_comb("p2head", 4'b0100, 1'b1, {HEAD, 32'h30});
      tick;
      chk_reg("p2head", 4'b0100, 1'b1, 3'd4, 1'b0);
      put(2, BODY, 32'h31);
      fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle;
         chk_comb("p2full", 4'b0000, 1'b0, 34'h0);
         tick;
         chk_reg("p2full", 4'b0100, 1'b1, 3'd4, 1'b0);
      end
      fifo_full = 1'b0;
      settle;
      chk_comb("p2body", 4'b0100, 1'b1, {BODY, 32'h31});
      tick;
      chk_reg("p2body", 4'b0100, 1'b1, 3'd4, 1'b0);
      put(2, HEAD, 32'h32);
      settle;
      chk_comb("p2badhead", 4'b0100, 1'b1, {HEAD, 32'h32});
      tick;
      chk_reg("p2badhead", 4'b0100, 1'b1, 3'd4, 1'b1);
      put(2, TAIL, 32'h33);
      settle;
      chk_comb("p2tail", 4'b0100, 1'b1, {TAIL, 32'h33});
      tick;
      chk_reg("p2tail", 4'b0000, 1'b0, 3'd5, 1'b1);
      drop(2);
      settle;
      chk_comb("idle", 4'b0000, 1'b0, 34'h0);

      // full in IDLE blocks a SINGLE
      put(1, SINGLE, 32'h40);
      fifo_full = 1'b1;
      settle;
      chk_comb("idlefull", 4'b0000, 1'b0, 34'h0);
      tick;
      chk_reg("idlefull", 4'b0000, 1'b0, 3'd5, 1'b1);
      fifo_full = 1'b0;
      settle;
      chk_comb("idleafter", 4'b0010, 1'b1, {SINGLE, 32'h40});
      tick;
      chk_reg("idleafter", 4'b0000, 1'b0, 3'd6, 1'b1);
      drop(1);

      // reset, then all four present SINGLEs continuously (counter wraps)
      settle;
      arst = 1'b0;
      #1;
      chk_reg("rst2", 4'b0000, 1'b0, 3'd0, 1'b0);
      for (int i = 0; i < N_REQ; i++) put(i, SINGLE, 32'(i));
      #1;
      chk_comb("rst2", 4'b0000, 1'b0, 34'h0);
      arst = 1'b1;
      #1;
      for (int k = 0; k < 10; k++) begin
         chk_comb("allsingle", 4'(1 << (k % 4)), 1'b1, {SINGLE, 32'(k % 4)});
         tick;
         chk_reg("allsingle", 4'b0000, 1'b0, 3'((k + 1) % 8), 1'b0);
         settle;
      end

      // reset in the middle of a packet
      for (int i = 0; i < N_REQ; i++) drop(i);
      put(1, HEAD, 32'h50);
      settle;
      chk_comb("p1mid_head", 4'b0010, 1'b1, {HEAD, 32'h50});
      tick;
      chk_reg("p1mid_head", 4'b0010, 1'b1, 3'd2, 1'b0);
      put(1, SINGLE, 32'h51);
      settle;
      chk_comb("p1mid_single", 4'b0010, 1'b1, {SINGLE, 32'h51});
      tick;
      chk_reg("p1mid_single", 4'b0010, 1'b1, 3'd2, 1'b1);
      put(1, BODY, 32'h52);
      settle;
      arst = 1'b0;
      #1;
      chk_reg("midreset", 4'b0000, 1'b0, 3'd0, 1'b0);
      chk_comb("midreset", 4'b0000, 1'b0, 34'h0);
      arst = 1'b1;
      put(3, SINGLE, 32'h60);
      #1;
      chk_comb("after_rst", 4'b1000, 1'b1, {SINGLE, 32'h60});
      tick;
      chk_reg("after_rst", 4'b0000, 1'b0, 3'd1, 1'b0);

      // FIFO error input sets the sticky flag
      for (int i = 0; i < N_REQ; i++) drop(i);
      fifo_error = 1'b1;
      settle;
      tick;
      fifo_error = 1'b0;
      chk_reg("fifoerr", 4'b0000, 1'b0, 3'd1, 1'b1);
      settle;
      tick;
      chk_reg("fifoerr_hold", 4'b0000, 1'b0, 3'd1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
